vote_frame_collector: RTL and testbench

- Serial front end for the voting evaluators.
- Collects N_VOTERS single-bit ballots, one per accepted valid/ready transfer, into a frame.
- Keeps a running yes-count, applies an enable gate and a threshold, and presents the parallel ballot vector and verdict on a valid/ready result port.
- Drives the combinational majority evaluators and also serves as their golden sequential model in MPC benchmark regression.

---
 rtl/vote_pkg.sv | 20 ++
 rtl/vote_ballot_shift.sv | 40 ++++
 rtl/vote_frame_collector.sv | 157 +++++++++++++++
 tb/tb_vote_frame_collector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot frame collector.
// Holds the frame FSM state encoding and sizing helpers.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DECIDE,
      HOLD
   } vote_state_t;

   localparam int VOTE_N_DEF   = 7;
   localparam int VOTE_THR_DEF = 4;

   // Bits needed to hold a count ranging over 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vote_ballot_shift.sv
// Ballot slice: write index, yes-count and ballot vector.
// Cleared at frame start, loaded once per accepted or abstained ballot.
module vote_ballot_shift
   import vote_pkg::*;
#(
   parameter int N_VOTERS = VOTE_N_DEF,
   parameter int CNT_W    = cnt_width(N_VOTERS),
   parameter int IDX_W    = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic                bit_in,
   output logic [IDX_W-1:0]    idx,
   output logic [CNT_W-1:0]    count,
   output logic [N_VOTERS-1:0] vec,
   output logic                last
);

   // Slot register: store the ballot at idx, bump count and idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         count <= '0;
         vec   <= '0;
      end else if (clear) begin
         idx   <= '0;
         count <= '0;
         vec   <= '0;
      end else if (load) begin
         vec[idx] <= bit_in;
         count    <= count + CNT_W'(bit_in);
         idx      <= idx + IDX_W'(1);
      end
   end

   assign last = (idx == IDX_W'(N_VOTERS - 1));

endmodule

// File: rtl/vote_frame_collector.sv
// Serial ballot collector with gated threshold verdict and result port.
// Optional macro VOTE_TIMEOUT_EN adds per-ballot abstain timeout.
module vote_frame_collector
   import vote_pkg::*;
#(
   parameter int N_VOTERS  = VOTE_N_DEF,
   parameter int THRESHOLD = VOTE_THR_DEF,
   parameter int CNT_W     = cnt_width(N_VOTERS),
   parameter int TO_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                gate_en,
   input  logic                ballot_valid,
   input  logic                ballot_bit,
   output logic                ballot_ready,
   output logic                result_valid,
   input  logic                result_ready,
   output logic                result_pass,
   output logic [CNT_W-1:0]    result_count,
   output logic [N_VOTERS-1:0] result_vec,
`ifdef VOTE_TIMEOUT_EN
   output logic                timeout_seen,
`endif
   output logic                busy
);

   localparam int IDX_W = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;

   if (N_VOTERS < 1 || N_VOTERS > 255 || THRESHOLD < 1 ||
       THRESHOLD > N_VOTERS || TO_CYCLES < 1) begin : g_bad_cfg
      $error("vote_frame_collector: bad parameter set");
   end

   vote_state_t state_q, state_d;

   logic                gate_q;
   logic                sh_clear;
   logic                sh_load;
   logic                sh_last;
   logic                xfer;
   logic                expire;
   logic                abst_q;
   logic [IDX_W-1:0]    sh_idx;
   logic [CNT_W-1:0]    sh_count;
   logic [N_VOTERS-1:0] sh_vec;

   assign ballot_ready = (state_q == COLLECT);
   assign busy         = (state_q != IDLE);
   assign xfer         = ballot_ready && ballot_valid;
   assign sh_load      = xfer || expire;

`ifdef VOTE_TIMEOUT_EN
   localparam int TO_W = cnt_width(TO_CYCLES);

   logic [TO_W-1:0] to_q;

   assign expire = ballot_ready && !ballot_valid &&
                   (to_q == TO_W'(TO_CYCLES - 1));

   // Wait timer: restarts on frame entry and on every slot fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_q   <= '0;
         abst_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         to_q   <= '0;
         abst_q <= 1'b0;
      end else if (state_q == COLLECT) begin
         if (sh_load) to_q <= '0;
         else         to_q <= to_q + TO_W'(1);
         if (expire)  abst_q <= 1'b1;
      end
   end
`else
   assign expire = 1'b0;
   assign abst_q = 1'b0;
`endif

   vote_ballot_shift #(
      .N_VOTERS (N_VOTERS),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W)
   ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (sh_clear),
      .load   (sh_load),
      .bit_in (xfer && ballot_bit),
      .idx    (sh_idx),
      .count  (sh_count),
      .vec    (sh_vec),
      .last   (sh_last)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and slice clear; start only honoured in IDLE.
   always_comb begin
      state_d  = state_q;
      sh_clear = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_clear = 1'b1;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            if (sh_load && sh_last) state_d = DECIDE;
         end
         DECIDE: state_d = HOLD;
         HOLD: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame enable captured with start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      gate_q <= 1'b0;
      else if (state_q == IDLE && start) gate_q <= gate_en;
   end

   // Result stage: loaded in DECIDE, valid dropped on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_valid <= 1'b0;
         result_pass  <= 1'b0;
         result_count <= '0;
         result_vec   <= '0;
`ifdef VOTE_TIMEOUT_EN
         timeout_seen <= 1'b0;
`endif
      end else if (state_q == DECIDE) begin
         result_valid <= 1'b1;
         result_pass  <= gate_q && (sh_count >= CNT_W'(THRESHOLD));
         result_count <= sh_count;
         result_vec   <= sh_vec;
`ifdef VOTE_TIMEOUT_EN
         timeout_seen <= abst_q;
`endif
      end else if (state_q == HOLD && result_ready) begin
         result_valid <= 1'b0;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{sh_idx, abst_q};

endmodule

// File: tb/tb_vote_frame_collector.sv
// Directed bench for vote_frame_collector (7 voters).
// Second instance with THRESHOLD=3 shares the stimulus.
module tb_vote_frame_collector;
   import vote_pkg::*;

   localparam int N = 7;
   localparam int W = 3;
`ifdef VOTE_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic gate_en = 1'b0;
   logic ballot_valid = 1'b0;
   logic ballot_bit = 1'b0;
   logic result_ready = 1'b0;

   logic         ballot_ready, result_valid, result_pass, busy;
   logic [W-1:0] result_count;
   logic [N-1:0] result_vec;
   logic         r3_ready, r3_valid, r3_pass, r3_busy;
   logic [W-1:0] r3_count;
   logic [N-1:0] r3_vec;
`ifdef VOTE_TIMEOUT_EN
   logic         timeout_seen, r3_ts;
`endif

   vote_frame_collector #(
      .N_VOTERS(N), .THRESHOLD(4), .TO_CYCLES(TO)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .gate_en(gate_en),
      .ballot_valid(ballot_valid), .ballot_bit(ballot_bit),
      .ballot_ready(ballot_ready), .result_valid(result_valid),
      .result_ready(result_ready), .result_pass(result_pass),
      .result_count(result_count), .result_vec(result_vec),
`ifdef VOTE_TIMEOUT_EN
      .timeout_seen(timeout_seen),
`endif
      .busy(busy)
   );

   vote_frame_collector #(
      .N_VOTERS(N), .THRESHOLD(3), .TO_CYCLES(TO)
   ) u_dut_t3 (
      .clk(clk), .rst_n(rst_n), .start(start), .gate_en(gate_en),
      .ballot_valid(ballot_valid), .ballot_bit(ballot_bit),
      .ballot_ready(r3_ready), .result_valid(r3_valid),
      .result_ready(result_ready), .result_pass(r3_pass),
      .result_count(r3_count), .result_vec(r3_vec),
`ifdef VOTE_TIMEOUT_EN
      .timeout_seen(r3_ts),
`endif
      .busy(r3_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start a frame, feed ballots back-to-back, return in first HOLD cycle.
   task automatic run_frame(input logic g, input logic [N-1:0] bits,
                            input string tag);
      @(negedge clk);
      start = 1'b1;
      gate_en = g;
      @(negedge clk);
      start = 1'b0;
      gate_en = 1'b0;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < N; i++) begin
         chk({tag, " ready"}, 32'(ballot_ready), 32'd1);
         ballot_valid = 1'b1;
         ballot_bit = bits[i];
         @(negedge clk);
      end
      ballot_bit = 1'b1;
      chk({tag, " ready drop"}, 32'(ballot_ready), 32'd0);
      chk({tag, " valid early"}, 32'(result_valid), 32'd0);
      @(negedge clk);
      ballot_valid = 1'b0;
      ballot_bit = 1'b0;
      chk({tag, " valid t+2"}, 32'(result_valid), 32'd1);
      chk({tag, " t3 valid"}, 32'(r3_valid), 32'd1);
   endtask

   typedef struct {
      logic         gate;
      logic         rdy_hi;
      logic [N-1:0] bits;
      int           cnt;
      logic         pass;
      logic         pass3;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 7'b0101011, 4, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 7'b0101001, 3, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 7'b1111111, 7, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 7'b1110001, 4, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 7'b0000000, 0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 7'b1111111, 7, 1'b1, 1'b1};

      @(negedge clk);
      chk("rst valid", 32'(result_valid), 32'd0);
      chk("rst ready", 32'(ballot_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst outs", 32'({result_pass, result_count, result_vec}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle ready", 32'(ballot_ready), 32'd0);

      for (int v = 0; v < 6; v++) begin
         string t;
         t = $sformatf("vec%0d", v);
         result_ready = tbl[v].rdy_hi;
         run_frame(tbl[v].gate, tbl[v].bits, t);
         chk({t, " count"}, 32'(result_count), 32'(tbl[v].cnt));
         chk({t, " pass"}, 32'(result_pass), 32'(tbl[v].pass));
         chk({t, " vec"}, 32'(result_vec), 32'(tbl[v].bits));
         chk({t, " t3 pass"}, 32'(r3_pass), 32'(tbl[v].pass3));
         chk({t, " t3 count"}, 32'(r3_count), 32'(tbl[v].cnt));
`ifdef VOTE_TIMEOUT_EN
         chk({t, " no timeout"}, 32'(timeout_seen), 32'd0);
`endif
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         chk({t, " consumed"}, 32'(result_valid), 32'd0);
         chk({t, " idle"}, 32'(busy), 32'd0);
         chk({t, " kept"}, 32'({result_count, result_vec}),
             32'({W'(tbl[v].cnt), tbl[v].bits}));
      end

      // Back-pressure in HOLD with start and ballots toggling.
      run_frame(1'b1, 7'b1110001, "hold");
      for (int k = 0; k < 5; k++) begin
         start = k[0];
         ballot_valid = 1'b1;
         ballot_bit = 1'b1;
         @(negedge clk);
         chk("hold valid", 32'(result_valid), 32'd1);
         chk("hold no accept", 32'(ballot_ready), 32'd0);
         chk("hold stable",
             32'({result_pass, result_count, result_vec}),
             32'({1'b1, 3'd4, 7'b1110001}));
      end
      start = 1'b1;
      result_ready = 1'b1;
      @(negedge clk);
      chk("hold release valid", 32'(result_valid), 32'd0);
      chk("start in hold ignored", 32'(busy), 32'd0);
      start = 1'b0;
      result_ready = 1'b0;
      ballot_valid = 1'b0;
      ballot_bit = 1'b0;
      @(negedge clk);
      chk("still idle", 32'(busy), 32'd0);

      // Reset mid-frame after three ballots.
      @(negedge clk);
      start = 1'b1;
      gate_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ballot_valid = 1'b1;
         ballot_bit = 1'b1;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort ready", 32'(ballot_ready), 32'd0);
      chk("abort outs", 32'({result_valid, result_count, result_vec}),
          32'd0);
      ballot_valid = 1'b0;
      ballot_bit = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort no result", 32'({result_valid, busy}), 32'd0);
      end
      run_frame(1'b1, 7'b0000000, "fresh");
      chk("fresh count", 32'(result_count), 32'd0);
      chk("fresh pass", 32'(result_pass), 32'd0);
      chk("fresh vec", 32'(result_vec), 32'd0);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;

`ifdef VOTE_TIMEOUT_EN
      begin
         int cyc;
         @(negedge clk);
         start = 1'b1;
         gate_en = 1'b1;
         @(negedge clk);
         start = 1'b0;
         gate_en = 1'b0;
         for (int i = 0; i < 5; i++) begin
            ballot_valid = 1'b1;
            ballot_bit = 1'b1;
            @(negedge clk);
         end
         ballot_valid = 1'b0;
         ballot_bit = 1'b0;
         cyc = 0;
         while (!result_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
         end
         chk("to latency", 32'(cyc), 32'd9);
         chk("to count", 32'(result_count), 32'd5);
         chk("to pass", 32'(result_pass), 32'd1);
         chk("to vec", 32'(result_vec), 32'(7'b0011111));
         chk("to seen", 32'(timeout_seen), 32'd1);
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
